apb_spi_master_arbiter: RTL and testbench
=========================================

Name: apb_spi_master_arbiter

Overview:
Shares one apb_spi_master APB slave port between NUM_REQ APB requesters (e.g. core and a DMA/boot engine). Arbitrates round-robin per APB transfer. Locks the SPI master to one requester from a command write until end-of-transfer (events_o[1] of the SPI master), so other requesters cannot interleave register accesses. A timeout releases a stuck lock.

Parameters:
NUM_REQ, 2, number of APB requesters (2..8)
APB_ADDR_WIDTH, 12, APB address width, equal on all ports
CMD_REG_OFFSET, 12'h000, SPI master offset whose write with rd/wr/qrd/qwr bits starts a transfer
LOCK_TIMEOUT, 4096, HCLK cycles a lock may persist without an owner access or eot; 0 disables the timeout

Ports:
HCLK  in  1  clock, single clock domain
HRESETn  in  1  asynchronous active-low reset
s_paddr  in  NUM_REQ*APB_ADDR_WIDTH  requester addresses, requester i at slice i
s_pwdata  in  NUM_REQ*32  requester write data
s_pwrite  in  NUM_REQ  requester write strobes
s_psel  in  NUM_REQ  requester selects
s_penable  in  NUM_REQ  requester enables
s_prdata  out  NUM_REQ*32  read data, valid in the requester's s_pready cycle
s_pready  out  NUM_REQ  per-requester ready
s_pslverr  out  NUM_REQ  per-requester error
m_paddr  out  APB_ADDR_WIDTH  to SPI master PADDR
m_pwdata  out  32  to PWDATA
m_pwrite  out  1  to PWRITE
m_psel  out  1  to PSEL
m_penable  out  1  to PENABLE
m_prdata  in  32  from PRDATA
m_pready  in  1  from PREADY
m_pslverr  in  1  from PSLVERR
eot_i  in  1  SPI master end-of-transfer pulse (events_o[1])
locked_o  out  1  lock held
owner_o  out  $clog2(NUM_REQ)  lock owner / last grant index
timeout_o  out  1  one-cycle pulse when a lock is released by timeout

Behaviour:
- Reset: state IDLE, lock clear, rr pointer = NUM_REQ-1 (requester 0 wins first), all outputs 0. Reset mid-transfer aborts it; no s_pready is issued.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: eligible = s_psel & (locked ? onehot(owner) : all). If any eligible, grant the first eligible index after the rr pointer (wrapping), register grant index and rr pointer = grant, go to SETUP. Otherwise stay.
- SETUP (1 cycle): m_psel=1, m_penable=0; m_paddr/m_pwdata/m_pwrite come from the granted requester.
- ACCESS: m_psel=1, m_penable=1, master signals held stable. While m_pready=0, stay (wait states).
- ACCESS with m_pready=1: for exactly that cycle, s_pready[grant]=1, s_prdata slice = m_prdata, s_pslverr[grant] = m_pslverr. Then go to IDLE.
- Minimum latency is 3 cycles from s_psel sampled in IDLE to s_pready. m_psel is low for at least 1 cycle (IDLE) between transfers.
- Non-granted requesters see s_pready=0 and s_pslverr=0, so they stall legally. Requesters must keep APB signals stable until their s_pready.
- Lock acquire: on completion of a write with m_pslverr=0, paddr==CMD_REG_OFFSET, pwdata[3:0]!=0 and pwdata[4]==0. Sets locked_o=1 and owner=grant.
- Lock release, any of:
  - eot_i=1;
  - owner completes a write to CMD_REG_OFFSET with pwdata[4]=1 (swrst);
  - timeout counter reaches LOCK_TIMEOUT-1.
- Acquire and eot_i in the same cycle: acquire wins, lock stays set.
- Timeout counter: clears on lock acquire and on every owner transfer completion. Counts every cycle while locked. On expiry: lock clears and timeout_o pulses 1 cycle. Inactive when LOCK_TIMEOUT=0.
- A requester that is mid-transfer when the lock is acquired by another requester is not aborted. Locks affect only IDLE grant selection.
- owner_o shows the lock owner while locked, otherwise the last grant index. The rr pointer advances on every grant, including grants made while locked.

Test Plan:
- Req0 reads 0x004, m_prdata=0xDEADBEEF, m_pready=1 in first ACCESS -> s_pready[0]=1 in cycle 3 after psel, s_prdata[31:0]=0xDEADBEEF; s_pready[1] stays 0.
- Both requesters hold reads from reset -> grants 0,1,0,1; m_psel low for 1 cycle between transfers.
- Req0 writes 0x000 data 0x1 -> locked_o=1, owner_o=0. Req1 read stalls while req0 reads 0x004 twice. eot_i pulse -> req1 granted in the next IDLE.
- LOCK_TIMEOUT=16, lock acquired, no eot and no owner access -> lock clears after 16 cycles, timeout_o=1 for one cycle, pending req1 is then served.
- m_pready held low for 3 ACCESS cycles, m_pslverr=1 on completion -> m_* stable throughout, s_pslverr[grant]=1, no lock taken even on a command write.
- HRESETn asserted during ACCESS while locked -> all outputs 0 immediately, locked_o=0. After release, requester 0 wins first.

Source files
------------

// File: rtl/apb_spi_master_arbiter.sv
// apb_spi_master_arbiter: shares one apb_spi_master APB slave port between
// NUM_REQ APB requesters. Grants round-robin per transfer. A command write
// locks the SPI master to its requester until eot_i, a soft reset or a timeout.
//
// Ports:
//   HCLK, HRESETn       clock, async active-low reset
//   s_*                 requester-side APB slaves, requester i at slice i
//   m_*                 master-side APB towards the SPI master
//   eot_i               SPI master end-of-transfer pulse
//   locked_o, owner_o   lock state and lock owner / last grant
//   timeout_o           one-cycle pulse when a lock expires
module apb_spi_master_arbiter #(
    parameter int                        NUM_REQ        = 2,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] CMD_REG_OFFSET = '0,
    parameter int                        LOCK_TIMEOUT   = 4096
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] s_paddr,
    input  logic [NUM_REQ*32-1:0]             s_pwdata,
    input  logic [NUM_REQ-1:0]                s_pwrite,
    input  logic [NUM_REQ-1:0]                s_psel,
    input  logic [NUM_REQ-1:0]                s_penable,
    output logic [NUM_REQ*32-1:0]             s_prdata,
    output logic [NUM_REQ-1:0]                s_pready,
    output logic [NUM_REQ-1:0]                s_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]         m_paddr,
    output logic [31:0]                       m_pwdata,
    output logic                              m_pwrite,
    output logic                              m_psel,
    output logic                              m_penable,
    input  logic [31:0]                       m_prdata,
    input  logic                              m_pready,
    input  logic                              m_pslverr,
    input  logic                              eot_i,
    output logic                              locked_o,
    output logic [$clog2(NUM_REQ)-1:0]        owner_o,
    output logic                              timeout_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_rr;
    logic                r_locked;
    logic [IW-1:0]       r_owner;
    logic [CW-1:0]       r_cnt;
    logic                r_timeout;

    logic [NUM_REQ-1:0]  w_mask;
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_idx;
    logic                w_active;
    logic                w_done;
    logic                w_cmd;
    logic                w_acq;
    logic                w_swrst;
    logic                w_to;
    logic                w_own_done;
    logic                w_unused;

    // Requester enables are not needed: the grant is taken from psel in IDLE
    // and the master-side phases are generated here.
    assign w_unused = ^s_penable;

    // While locked only the owner may be granted.
    assign w_mask = r_locked ? (NUM_REQ'(1) << r_owner) : '1;
    assign w_elig = s_psel & w_mask;

    // First eligible index after the rr pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IW'((int'(r_rr) + i) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_psel      = 1'b0;
        m_penable   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) w_state_nxt = SETUP;
            end
            SETUP: begin
                m_psel      = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
                if (m_pready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Master-side request fields are zero outside a transfer.
    assign w_active = (r_state != IDLE);
    assign m_paddr  = w_active ?
        s_paddr[int'(r_grant)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] : '0;
    assign m_pwdata = w_active ? s_pwdata[int'(r_grant)*32 +: 32] : '0;
    assign m_pwrite = w_active & s_pwrite[r_grant];

    assign w_done = (r_state == ACCESS) && m_pready;

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        if (w_done) begin
            s_pready[r_grant]              = 1'b1;
            s_pslverr[r_grant]             = m_pslverr;
            s_prdata[int'(r_grant)*32 +: 32] = m_prdata;
        end
    end

    assign w_cmd      = w_done && m_pwrite && (m_paddr == CMD_REG_OFFSET);
    assign w_acq      = w_cmd && !m_pslverr &&
                        (m_pwdata[3:0] != 4'd0) && !m_pwdata[4];
    assign w_own_done = w_done && r_locked && (r_grant == r_owner);
    assign w_swrst    = w_cmd && m_pwdata[4] && w_own_done;
    assign w_to       = (LOCK_TIMEOUT != 0) && r_locked &&
                        (r_cnt == CW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rr    <= IW'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_pick;
                r_rr    <= w_pick;
            end
        end
    end

    // Acquire has priority over every release source.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_locked  <= 1'b0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_acq) begin
                r_locked <= 1'b1;
                r_owner  <= r_grant;
                r_cnt    <= '0;
            end else if (eot_i || w_swrst || w_to) begin
                r_locked  <= 1'b0;
                r_cnt     <= '0;
                r_timeout <= w_to;
            end else if (r_locked) begin
                if (w_own_done) r_cnt <= '0;
                else            r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign locked_o  = r_locked;
    assign owner_o   = r_locked ? r_owner : r_grant;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_apb_spi_master_arbiter.sv
// tb_apb_spi_master_arbiter: scoreboard bench for apb_spi_master_arbiter
// with two requesters and a small APB slave model on the master side.
module tb_apb_spi_master_arbiter;

    localparam int N  = 2;
    localparam int AW = 12;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [N*AW-1:0] s_paddr;
    logic [N*32-1:0] s_pwdata;
    logic [N-1:0]    s_pwrite, s_psel, s_penable;
    logic [N*32-1:0] s_prdata;
    logic [N-1:0]    s_pready, s_pslverr;
    logic [AW-1:0]   m_paddr;
    logic [31:0]     m_pwdata, m_prdata;
    logic            m_pwrite, m_psel, m_penable, m_pready, m_pslverr;
    logic            eot_i = 1'b0;
    logic            locked_o, timeout_o;
    logic [0:0]      owner_o;

    logic [AW-1:0] rq_addr [N];
    logic [31:0]   rq_wdata[N];
    logic          rq_write[N], rq_sel[N], rq_en[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_paddr[i*AW +: AW]  = rq_addr[i];
            s_pwdata[i*32 +: 32] = rq_wdata[i];
            s_pwrite[i]          = rq_write[i];
            s_psel[i]            = rq_sel[i];
            s_penable[i]         = rq_en[i];
        end
    end

    apb_spi_master_arbiter #(
        .NUM_REQ(N), .APB_ADDR_WIDTH(AW),
        .CMD_REG_OFFSET(12'h000), .LOCK_TIMEOUT(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_psel(s_psel), .s_penable(s_penable), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .eot_i(eot_i), .locked_o(locked_o), .owner_o(owner_o),
        .timeout_o(timeout_o)
    );

    // Slave model: sl_waits wait states, then ready; data from address.
    int          sl_waits = 0;
    int          sl_cnt;
    logic        sl_err = 1'b0;
    logic        sl_fix = 1'b0;
    logic [31:0] sl_fix_val = 32'h0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sl_cnt <= 0;
        else if (m_psel && m_penable && !m_pready) sl_cnt <= sl_cnt + 1;
        else sl_cnt <= 0;
    end

    assign m_pready  = m_psel && m_penable && (sl_cnt >= sl_waits);
    assign m_prdata  = sl_fix ? sl_fix_val : (32'hC0DE0000 | 32'(m_paddr));
    assign m_pslverr = m_pready && sl_err;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [32:0] sb0[$];
    logic [32:0] sb1[$];
    int          order[$];

    logic          prev_psel = 1'b0;
    logic [44:0]   snap;
    logic [32:0]   e_pop;

    always @(negedge HCLK) begin
        if (m_psel && !m_penable) begin
            chk("m_psel_gap", prev_psel, 0);
            snap = {m_pwrite, m_paddr, m_pwdata};
        end
        if (m_psel && m_penable)
            chk("m_stable", {m_pwrite, m_paddr, m_pwdata}, snap);
        if (s_pready != '0)
            chk("one_ready", $countones(s_pready), 1);
        if (s_pslverr != '0)
            chk("err_mask", s_pslverr & ~s_pready, 0);
        for (int i = 0; i < N; i++) begin
            if (s_pready[i]) begin
                order.push_back(i);
                chk("sb_nonempty",
                    ((i == 0) ? sb0.size() : sb1.size()) != 0, 1);
                if ((i == 0) ? (sb0.size() != 0) : (sb1.size() != 0)) begin
                    e_pop = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk("rdata", s_prdata[i*32 +: 32], e_pop[31:0]);
                    chk("slverr", s_pslverr[i], e_pop[32]);
                end
            end
        end
        prev_psel = m_psel;
    end

    task automatic xfer(input int i, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic w,
                        input logic err, output int cyc);
        logic [32:0] e;
        logic        done;
        e = {err, sl_fix ? sl_fix_val : (32'hC0DE0000 | 32'(a))};
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge HCLK); #1;
        rq_addr[i]  = a;
        rq_wdata[i] = d;
        rq_write[i] = w;
        rq_sel[i]   = 1'b1;
        rq_en[i]    = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (cyc < 200) begin
            @(negedge HCLK);
            cyc++;
            rq_en[i] = 1'b1;
            if (s_pready[i]) begin
                done = 1'b1;
                break;
            end
        end
        chk("req_done", done, 1);
        @(posedge HCLK); #1;
        rq_sel[i] = 1'b0;
        rq_en[i]  = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    int c0, c1, n;

    initial begin
        for (int i = 0; i < N; i++) begin
            rq_addr[i] = '0; rq_wdata[i] = '0; rq_write[i] = 1'b0;
            rq_sel[i] = 1'b0; rq_en[i] = 1'b0;
        end

        @(negedge HCLK);
        chk("rst_psel", {m_psel, m_penable}, 0);
        chk("rst_ready", s_pready, 0);
        chk("rst_lock", {locked_o, owner_o, timeout_o}, 0);
        chk("rst_addr", m_paddr, 0);
        #1 HRESETn = 1'b1;

        // Single read with fixed data, zero wait states.
        sl_fix = 1'b1; sl_fix_val = 32'hDEADBEEF;
        xfer(0, 12'h004, 32'h0, 1'b0, 1'b0, c0);
        chk("t1_latency", c0, 3);
        sl_fix = 1'b0;

        // Round-robin between two continuous requesters.
        do_reset();
        order.delete();
        fork
            begin
                xfer(0, 12'h010, 0, 1'b0, 1'b0, c0);
                xfer(0, 12'h014, 0, 1'b0, 1'b0, c0);
            end
            begin
                xfer(1, 12'h020, 0, 1'b0, 1'b0, c1);
                xfer(1, 12'h024, 0, 1'b0, 1'b0, c1);
            end
        join
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk("rr_order", order[k], k % 2);

        // Lock by req0, req1 stalls until eot.
        order.delete();
        xfer(0, 12'h000, 32'h1, 1'b1, 1'b0, c0);
        chk("lock_set", locked_o, 1);
        chk("lock_owner", owner_o, 0);
        fork
            xfer(1, 12'h008, 0, 1'b0, 1'b0, c1);
            begin
                xfer(0, 12'h004, 0, 1'b0, 1'b0, c0);
                xfer(0, 12'h004, 0, 1'b0, 1'b0, c0);
                repeat (4) @(posedge HCLK);
                chk("lock_pending", sb1.size(), 1);
                chk("lock_hold", locked_o, 1);
                #1 eot_i = 1'b1;
                @(posedge HCLK); #1 eot_i = 1'b0;
                chk("eot_release", locked_o, 0);
            end
        join
        chk("lock_count", order.size(), 4);
        if (order.size() == 4)
            chk("lock_order", {order[0], order[1], order[2], order[3]},
                {32'd0, 32'd0, 32'd0, 32'd1});

        // Lock expires by timeout; pending req1 then served.
        xfer(0, 12'h000, 32'h2, 1'b1, 1'b0, c0);
        chk("to_lock", locked_o, 1);
        fork
            xfer(1, 12'h00C, 0, 1'b0, 1'b0, c1);
            begin
                n = 0;
                while (n < 100) begin
                    @(negedge HCLK);
                    if (!locked_o) break;
                    n++;
                end
                chk("to_len", n, 16);
                chk("to_pulse", timeout_o, 1);
                @(negedge HCLK);
                chk("to_pulse_end", timeout_o, 0);
            end
        join
        chk("to_served", sb1.size(), 0);

        // Wait states with slave error on a command write: no lock.
        sl_waits = 3; sl_err = 1'b1;
        xfer(1, 12'h000, 32'h1, 1'b1, 1'b1, c1);
        chk("ws_latency", c1, 6);
        chk("ws_nolock", locked_o, 0);
        chk("ws_owner", owner_o, 1);
        sl_waits = 0; sl_err = 1'b0;

        // Reset during ACCESS while locked.
        xfer(0, 12'h000, 32'h1, 1'b1, 1'b0, c0);
        chk("rl_lock", locked_o, 1);
        sl_waits = 5;
        @(posedge HCLK); #1;
        rq_addr[0] = 12'h004; rq_write[0] = 1'b0; rq_sel[0] = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge HCLK);
            rq_en[0] = 1'b1;
            if (m_penable) break;
            n++;
        end
        chk("rl_access", m_penable, 1);
        HRESETn = 1'b0;
        #1;
        chk("rl_m", {m_psel, m_penable, m_paddr}, 0);
        chk("rl_s", {s_pready, s_pslverr}, 0);
        chk("rl_lock_clr", {locked_o, owner_o, timeout_o}, 0);
        rq_sel[0] = 1'b0; rq_en[0] = 1'b0;
        sl_waits = 0;
        @(posedge HCLK); #1 HRESETn = 1'b1;
        order.delete();
        fork
            xfer(1, 12'h030, 0, 1'b0, 1'b0, c1);
            xfer(0, 12'h034, 0, 1'b0, 1'b0, c0);
        join
        chk("rl_count", order.size(), 2);
        if (order.size() == 2)
            chk("rl_first", {order[0], order[1]}, {32'd0, 32'd1});

        repeat (2) @(posedge HCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
